xor_mux_serial: RTL and testbench

Bit-serial XOR-and-parity engine. Accepts two WIDTH-bit operands over a valid/ready handshake, computes their bitwise XOR LANES bits per clock using only mux-built XOR cells, and accumulates the parity of the result. Returns the result word and its parity over a second valid/ready handshake. Sits in the combinational-logic exercises as the sequential, parametrised successor of the single-gate mux-built XOR.

---
 rtl/xor_mux_pkg.sv | 10 +
 rtl/mux.sv | 11 +
 rtl/xor_mux_cell.sv | 25 ++
 rtl/xor_mux_serial.sv | 129 ++++++++++++
 tb/tb_xor_mux_serial.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_mux_pkg.sv
// Shared types for the bit-serial mux-built XOR / parity engine.
package xor_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : xor_mux_pkg

// File: rtl/mux.sv
// 2:1 multiplexer: y = sel ? d1 : d0. Primitive the XOR cell is built from.
module mux (
    input  logic d0_i,
    input  logic d1_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule : mux

// File: rtl/xor_mux_cell.sv
// 1-bit XOR composed only of two muxes and the constants 0 and 1.
module xor_mux_cell (
    input  logic a_i,
    input  logic b_i,
    output logic o_o
);

    logic nb;

    // nb = !b, then a selects between b and !b
    mux u_inv (
        .d0_i  (1'b1),
        .d1_i  (1'b0),
        .sel_i (b_i),
        .y_o   (nb)
    );

    mux u_sel (
        .d0_i  (b_i),
        .d1_i  (nb),
        .sel_i (a_i),
        .y_o   (o_o)
    );

endmodule : xor_mux_cell

// File: rtl/xor_mux_serial.sv
// Bit-serial XOR of two WIDTH-bit words, LANES bits per cycle, with parity of
// the result; valid/ready on both the operand and the result side.
module xor_mux_serial
    import xor_mux_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LANES      = 2,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_y,
    output logic             down_parity
);

    localparam int unsigned STEPS = (LANES == 0) ? 1 : (WIDTH / LANES);
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    if (WIDTH < 1 || LANES < 1 || (LANES > 0 && (WIDTH % LANES) != 0)) begin : g_bad_cfg
        $error("xor_mux_serial: WIDTH must be >= 1 and divisible by LANES");
    end

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, y_q;
    logic [WIDTH-1:0]   a_d, b_d, y_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               par_q, par_d;
    logic               up_ready_q, down_valid_q, down_parity_q;
    logic [LANES-1:0]   lane_y;

    // Per-lane XOR plus a ripple of XOR cells folding lane bits into parity
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic p_in;
        logic p_out;

        xor_mux_cell u_xor (
            .a_i (a_q[i]),
            .b_i (b_q[i]),
            .o_o (lane_y[i])
        );

        if (i == 0) begin : g_head
            assign p_in = par_q;
        end else begin : g_link
            assign p_in = g_lane[i-1].p_out;
        end

        xor_mux_cell u_par (
            .a_i (p_in),
            .b_i (lane_y[i]),
            .o_o (p_out)
        );
    end

    assign par_d = g_lane[LANES-1].p_out;

    // Operands drain from the LSB; results enter at the MSB so the first
    // lane group ends up at the bottom after STEPS shifts.
    if (LANES < WIDTH) begin : g_shift
        assign a_d = {{LANES{1'b0}}, a_q[WIDTH-1:LANES]};
        assign b_d = {{LANES{1'b0}}, b_q[WIDTH-1:LANES]};
        assign y_d = {lane_y, y_q[WIDTH-1:LANES]};
    end else begin : g_single
        assign a_d = '0;
        assign b_d = '0;
        assign y_d = lane_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            par_q         <= 1'b0;
            up_ready_q    <= 1'b1;
            down_valid_q  <= 1'b0;
            down_parity_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (up_valid && up_ready_q) begin
                        a_q        <= up_a;
                        b_q        <= up_b;
                        cnt_q      <= '0;
                        par_q      <= 1'b0;
                        up_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    y_q   <= y_d;
                    par_q <= par_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        down_valid_q  <= 1'b1;
                        down_parity_q <= ODD_PARITY ? ~par_d : par_d;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        down_valid_q <= 1'b0;
                        up_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign up_ready    = up_ready_q;
    assign down_valid  = down_valid_q;
    assign down_y      = y_q;
    assign down_parity = down_parity_q;

endmodule : xor_mux_serial

// File: tb/tb_xor_mux_serial.sv
// Self-checking bench: four configurations share stimulus and are compared
// every cycle against a transaction-level timing/arithmetic model.
module tb_xor_mux_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_valid = 1'b0;
    logic [7:0] up_a = '0;
    logic [7:0] up_b = '0;
    logic       down_ready = 1'b0;

    logic       up_ready    [4];
    logic       down_valid  [4];
    logic [7:0] down_y      [4];
    logic       down_parity [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: LANES=2 even, 1: LANES=2 odd, 2: LANES=8 even, 3: LANES=1 even
    xor_mux_serial #(.WIDTH(8), .LANES(2), .ODD_PARITY(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready[0]),
        .up_a(up_a), .up_b(up_b), .down_valid(down_valid[0]), .down_ready(down_ready),
        .down_y(down_y[0]), .down_parity(down_parity[0]));
    xor_mux_serial #(.WIDTH(8), .LANES(2), .ODD_PARITY(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready[1]),
        .up_a(up_a), .up_b(up_b), .down_valid(down_valid[1]), .down_ready(down_ready),
        .down_y(down_y[1]), .down_parity(down_parity[1]));
    xor_mux_serial #(.WIDTH(8), .LANES(8), .ODD_PARITY(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready[2]),
        .up_a(up_a), .up_b(up_b), .down_valid(down_valid[2]), .down_ready(down_ready),
        .down_y(down_y[2]), .down_parity(down_parity[2]));
    xor_mux_serial #(.WIDTH(8), .LANES(1), .ODD_PARITY(1'b0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready[3]),
        .up_a(up_a), .up_b(up_b), .down_valid(down_valid[3]), .down_ready(down_ready),
        .down_y(down_y[3]), .down_parity(down_parity[3]));

    function automatic int steps_of(input int k);
        case (k)
            0, 1:    return 4;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: a word is held from its accept cycle; its result is visible
    // once STEPS cycles have elapsed and leaves on the first ready edge after.
    int         cyc = 0;
    bit         has_word [4] = '{default: 1'b0};
    int         acc_cyc  [4];
    logic [7:0] wy       [4];
    logic       wp       [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) has_word[k] = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!has_word[k]) begin
                    if (up_valid) begin
                        has_word[k] = 1'b1;
                        acc_cyc[k]  = cyc;
                        wy[k]       = up_a ^ up_b;
                        wp[k]       = (($countones(up_a ^ up_b) % 2) == 1) != (k == 1);
                    end
                end else if (cyc > acc_cyc[k] + steps_of(k) && down_ready) begin
                    has_word[k] = 1'b0;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            bit ev;
            ev = has_word[k] && (cyc > acc_cyc[k] + steps_of(k));
            chk("up_ready", k, 32'(up_ready[k]), 32'(!has_word[k]));
            chk("down_valid", k, 32'(down_valid[k]), 32'(ev));
            if (ev) begin
                chk("down_y", k, 32'(down_y[k]), 32'(wy[k]));
                chk("down_parity", k, 32'(down_parity[k]), 32'(wp[k]));
            end
            if (!rst_n) begin
                chk("rst_y", k, 32'(down_y[k]), 32'h0);
                chk("rst_parity", k, 32'(down_parity[k]), 32'h0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One word through all four instances; pins results and latencies to literals
    task automatic run_word(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] ey, input logic [3:0] ep);
        int lat [4];
        int lat_exp [4];
        for (int k = 0; k < 4; k++) begin
            lat[k]     = -1;
            lat_exp[k] = steps_of(k);
        end
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_a       = a;
        up_b       = b;
        tick();
        up_valid = 1'b0;
        up_a     = $urandom;
        up_b     = $urandom;
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (down_valid[k] && lat[k] < 0) begin
                    lat[k] = n;
                    chk("lit_y", k, 32'(down_y[k]), 32'(ey));
                    chk("lit_parity", k, 32'(down_parity[k]), 32'(ep[k]));
                end
            end
            tick();
        end
        for (int k = 0; k < 4; k++) chk("lit_latency", k, lat[k], lat_exp[k]);
    endtask

    initial begin
        int seen;
        int last_t;
        int n_res;
        bit all_dv;

        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("reset_up_ready", k, 32'(up_ready[k]), 32'h1);
            chk("reset_down_valid", k, 32'(down_valid[k]), 32'h0);
            chk("reset_down_y", k, 32'(down_y[k]), 32'h0);
        end
        rst_n = 1'b1;
        tick();

        run_word(8'hA5, 8'h0F, 8'hAA, 4'b0010);
        run_word(8'h01, 8'h00, 8'h01, 4'b1101);
        run_word(8'hC3, 8'h5A, 8'h99, 4'b0010);

        // Backpressure: result held, new offer dropped
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_a       = 8'h12;
        up_b       = 8'h34;
        tick();
        up_valid = 1'b0;
        all_dv   = 1'b0;
        for (int n = 0; n < 12 && !all_dv; n++) begin
            tick();
            all_dv = down_valid[0] && down_valid[1] && down_valid[2] && down_valid[3];
        end
        chk("bp_all_done", 0, 32'(all_dv), 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_y", 0, 32'(down_y[0]), 32'h26);
            chk("bp_parity", 0, 32'(down_parity[0]), 32'h1);
            chk("bp_parity_odd", 1, 32'(down_parity[1]), 32'h0);
            chk("bp_up_ready", 0, 32'(up_ready[0]), 32'h0);
            up_valid = (i == 1);
            up_a     = 8'hFF;
            up_b     = 8'h00;
            tick();
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        tick();
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            if (down_valid[0] || !up_ready[0]) seen++;
            tick();
        end
        chk("bp_pulse_dropped", 0, seen, 0);

        // Reset two RUN cycles into a word
        up_valid = 1'b1;
        up_a     = 8'hFF;
        up_b     = 8'h00;
        tick();
        up_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_down_valid", 0, 32'(down_valid[0]), 32'h0);
        chk("midrst_up_ready", 0, 32'(up_ready[0]), 32'h1);
        chk("midrst_down_y", 0, 32'(down_y[0]), 32'h0);
        chk("midrst_parity", 0, 32'(down_parity[0]), 32'h0);
        chk("midrst_down_valid_l8", 2, 32'(down_valid[2]), 32'h0);
        tick();
        rst_n = 1'b1;
        seen  = 0;
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < 4; k++) if (down_valid[k]) seen++;
            tick();
        end
        chk("midrst_no_result", 0, seen, 0);
        run_word(8'h3C, 8'h3C, 8'h00, 4'b0010);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            up_valid   = ($urandom_range(0, 3) != 0);
            up_a       = $urandom;
            up_b       = $urandom;
            down_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        repeat (12) tick();

        // Back-to-back with both handshakes held high
        up_valid = 1'b1;
        last_t   = -1;
        n_res    = 0;
        for (int t = 0; t < 60; t++) begin
            if (down_valid[0]) begin
                if (last_t >= 0) chk("b2b_spacing", 0, t - last_t, 6);
                last_t = t;
                n_res++;
            end
            up_a = $urandom;
            up_b = $urandom;
            tick();
        end
        chk("b2b_count", 0, 32'(n_res >= 9), 32'h1);
        up_valid = 1'b0;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_xor_mux_serial
